// File: rtl/uart_hamming_pkg.sv
// ---------------------------------------------------------------------------
// uart_hamming_pkg
//
// Shared definitions for the Hamming(12,8) UART transmitter and receiver.
//   - tx_state_e : transmit FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   - CODE_W / DATA_W : codeword and payload widths
//   - PAR_POS_* : bit positions of the four parity bits inside c[11:0]
//   - CYCLES_PER_BIT_DEFAULT : default bit period in clk cycles
// ---------------------------------------------------------------------------
package uart_hamming_pkg;

  localparam int CODE_W = 12;
  localparam int DATA_W = 8;

  // Parity bits sit at the power-of-two positions of the 1-based Hamming
  // numbering, i.e. 1,2,4,8 -> zero-based 0,1,3,7.
  localparam int PAR_POS_0 = 0;
  localparam int PAR_POS_1 = 1;
  localparam int PAR_POS_2 = 3;
  localparam int PAR_POS_3 = 7;

  localparam int CYCLES_PER_BIT_DEFAULT = 868;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage : uart_hamming_pkg

// File: rtl/hamming_enc_12_8.sv
// ---------------------------------------------------------------------------
// hamming_enc_12_8
//
// Purely combinational Hamming(12,8) encoder.
// Ports:
//   i_d [7:0]   data byte
//   o_c [11:0]  codeword; data at c[11:8]=d[7:4], c[6:4]=d[3:1], c[2]=d[0],
//               parity at c[0], c[1], c[3], c[7]
// ---------------------------------------------------------------------------
module hamming_enc_12_8
  import uart_hamming_pkg::*;
(
  input  logic [DATA_W-1:0] i_d,
  output logic [CODE_W-1:0] o_c
);

  // Systematic bits placed in the codeword, parity slots still zero.
  logic [CODE_W-1:0] w_sys;

  assign w_sys = {i_d[7:4], 1'b0, i_d[3:1], 1'b0, i_d[0], 2'b00};

  // Each parity bit covers the positions whose 1-based index has the
  // corresponding power-of-two bit set.
  always_comb begin
    o_c            = w_sys;
    o_c[PAR_POS_0] = w_sys[2] ^ w_sys[4] ^ w_sys[6] ^ w_sys[8] ^ w_sys[10];
    o_c[PAR_POS_1] = w_sys[2] ^ w_sys[5] ^ w_sys[6] ^ w_sys[9] ^ w_sys[10];
    o_c[PAR_POS_2] = w_sys[4] ^ w_sys[5] ^ w_sys[6] ^ w_sys[11];
    o_c[PAR_POS_3] = w_sys[8] ^ w_sys[9] ^ w_sys[10] ^ w_sys[11];
  end

endmodule : hamming_enc_12_8

// File: rtl/hamming_uart_tx.sv
// ---------------------------------------------------------------------------
// hamming_uart_tx
//
// UART transmitter sending one Hamming(12,8) codeword per frame:
// start bit (0), 12 codeword bits MSB first, stop bit (1); every bit lasts
// CYCLES_PER_BIT clk cycles, so a frame keeps t_busy high 14*CYCLES_PER_BIT
// cycles.
//
// Parameters:
//   CYCLES_PER_BIT  clk cycles per serial bit (2..1023)
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   parallel_in  byte to send, sampled only when a request is accepted
//   t_enable     send request, accepted only while idle
//   err_pos      (TX_ERR_INJECT_EN only) 1..12 inverts c[err_pos-1]
//   serial_out   registered UART line, idle high
//   t_busy       high while a frame is in progress
//
// Build option: define TX_ERR_INJECT_EN to add the err_pos port and the
// single-bit error injection used for receiver correction testing.
// ---------------------------------------------------------------------------
module hamming_uart_tx
  import uart_hamming_pkg::*;
#(
  parameter int CYCLES_PER_BIT = CYCLES_PER_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] parallel_in,
  input  logic              t_enable,
`ifdef TX_ERR_INJECT_EN
  input  logic [3:0]        err_pos,
`endif
  output logic              serial_out,
  output logic              t_busy
);

  localparam logic [9:0] CNT_LAST = 10'(CYCLES_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST = 4'(CODE_W - 1);

  tx_state_e         r_state;
  logic [9:0]        r_cyc_cnt;
  logic [3:0]        r_bit_cnt;
  logic [CODE_W-1:0] r_code;
  logic              r_serial_out;
  logic              r_busy;

  logic [CODE_W-1:0] w_enc_code;
  logic [CODE_W-1:0] w_flip_mask;
  logic [CODE_W-1:0] w_tx_code;
  logic [3:0]        w_next_idx;
  logic              w_bit_done;

  hamming_enc_12_8 u_enc (
    .i_d (parallel_in),
    .o_c (w_enc_code)
  );

`ifdef TX_ERR_INJECT_EN
  // Positions 0 and 13..15 are "no error"; the shift is only meaningful
  // for 1..12.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_flip_mask = '0;
    if (err_pos >= 4'd1 && err_pos <= 4'd12) begin
      w_flip_mask = CODE_W'(1) << (err_pos - 4'd1);
    end
  end
`else
  assign w_flip_mask = '0;
`endif

  assign w_tx_code  = w_enc_code ^ w_flip_mask;
  assign w_bit_done = (r_cyc_cnt == CNT_LAST);

  // Index of the codeword bit that follows the current one (MSB first).
  // Unused when the last data bit is on the line.
  assign w_next_idx = 4'(CODE_W - 2) - r_bit_cnt;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the codeword register is an ordinary flop bank (not a memory),
      // so clearing it on reset is cheap and keeps post-reset state defined.
      r_state      <= IDLE;
      r_cyc_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_code       <= '0;
      r_serial_out <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cyc_cnt    <= '0;
          r_bit_cnt    <= '0;
          r_serial_out <= 1'b1;
          r_busy       <= 1'b0;
          if (t_enable) begin
            r_code       <= w_tx_code;
            r_state      <= START;
            r_serial_out <= 1'b0;
            r_busy       <= 1'b1;
          end
        end

        START: begin
          if (w_bit_done) begin
            r_cyc_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_state      <= DATA;
            r_serial_out <= r_code[CODE_W-1];
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 10'd1;
          end
        end

        DATA: begin
          if (w_bit_done) begin
            r_cyc_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt    <= '0;
              r_state      <= STOP;
              r_serial_out <= 1'b1;
            end else begin
              r_bit_cnt    <= r_bit_cnt + 4'd1;
              r_serial_out <= r_code[w_next_idx];
            end
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 10'd1;
          end
        end

        STOP: begin
          if (w_bit_done) begin
            r_cyc_cnt <= '0;
            r_state   <= IDLE;
            r_busy    <= 1'b0;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 10'd1;
          end
        end

        default: begin
          r_state      <= IDLE;
          r_cyc_cnt    <= '0;
          r_bit_cnt    <= '0;
          r_serial_out <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign serial_out = r_serial_out;
  assign t_busy     = r_busy;

endmodule : hamming_uart_tx

// File: tb/tb_hamming_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_hamming_uart_tx
//
// Self-checking bench for hamming_uart_tx with CYCLES_PER_BIT=5. The line is
// checked every cycle against a frame built from a Hamming model written in
// 1-based position form; a bench-side receiver samples mid-bit and decodes
// with a syndrome to recover each byte.
// ---------------------------------------------------------------------------
module tb_hamming_uart_tx;

  localparam int CPB     = 5;
  localparam int FRAME_C = 14 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] parallel_in;
  logic       t_enable;
  logic [3:0] err_pos;
  logic       serial_out;
  logic       t_busy;

  int errors = 0;
  int checks = 0;

  hamming_uart_tx #(.CYCLES_PER_BIT(CPB)) dut (
    .clk         (clk),
    .reset       (reset),
    .parallel_in (parallel_in),
    .t_enable    (t_enable),
`ifdef TX_ERR_INJECT_EN
    .err_pos     (err_pos),
`endif
    .serial_out  (serial_out),
    .t_busy      (t_busy)
  );

  always #5 clk = ~clk;

  // Hamming(12,8) in classic form: positions 1..12, parity at powers of two,
  // parity p covers every position whose index has bit p set.
  function automatic logic [11:0] model_code(input logic [7:0] d);
    logic [12:1] p;
    int k;
    logic par;
    p = '0;
    k = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        p[pos] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 12; pos++)
        if ((pos & (1 << b)) != 0) par = par ^ p[pos];
      p[1 << b] = par;
    end
    return p;
  endfunction

  function automatic logic [11:0] inject_mask(input logic [3:0] ep);
`ifdef TX_ERR_INJECT_EN
    if (ep >= 1 && ep <= 12) return 12'(1) << (ep - 1);
`endif
    return 12'h000;
  endfunction

  // Syndrome decode: XOR of 1-based indices of set bits names the bad bit.
  function automatic logic [7:0] model_decode(input logic [11:0] c);
    logic [11:0] w;
    int syn;
    int k;
    logic [7:0] d;
    w   = c;
    syn = 0;
    for (int i = 0; i < 12; i++) if (w[i]) syn = syn ^ (i + 1);
    if (syn >= 1 && syn <= 12) w[syn-1] = ~w[syn-1];
    k = 0;
    d = '0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = w[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  // Walk n frame cycles starting at frame cycle 0, comparing the line each
  // cycle. Optionally pokes a 0x3C request at cycle `poke` and scrambles
  // parallel_in while the frame is in flight.
  task automatic walk_frame(input logic [11:0] exp, input int n, input int poke,
                            input bit scramble, input string name,
                            output logic [11:0] rx);
    int  slot;
    logic exp_bit;
    rx = '0;
    for (int i = 0; i < n; i++) begin
      slot    = i / CPB;
      exp_bit = (slot == 0) ? 1'b0 : (slot == 13) ? 1'b1 : exp[12 - slot];
      checks++;
      if ({t_busy, serial_out} !== {1'b1, exp_bit}) begin
        errors++;
        $display("FAIL %s cycle %0d: busy/line got %b%b expected 1%b",
                 name, i, t_busy, serial_out, exp_bit);
      end
      if (slot >= 1 && slot <= 12 && (i % CPB) == CPB / 2)
        rx[12 - slot] = serial_out;
      t_enable = (i == poke);
      if (i == poke) parallel_in = 8'h3C;
      else if (scramble) parallel_in = 8'($urandom);
      @(negedge clk);
    end
    t_enable = 1'b0;
  endtask

  // Launch a frame from an idle negedge, check all of it, and finish on the
  // first idle negedge afterwards (so calls can run back to back).
  task automatic send_frame(input logic [7:0] d, input logic [3:0] ep,
                            input int poke, input bit scramble,
                            input string name, output logic [11:0] rx);
    logic [11:0] exp;
    checks++;
    if (t_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pre-idle: t_busy got %b expected 0", name, t_busy);
    end
    exp         = model_code(d) ^ inject_mask(ep);
    parallel_in = d;
    err_pos     = ep;
    t_enable    = 1'b1;
    @(negedge clk);
    t_enable = 1'b0;
    walk_frame(exp, FRAME_C, poke, scramble, name, rx);
    checks++;
    if ({t_busy, serial_out} !== 2'b01) begin
      errors++;
      $display("FAIL %s post-frame: busy/line got %b%b expected 01",
               name, t_busy, serial_out);
    end
    checks++;
    if (model_decode(rx) !== d) begin
      errors++;
      $display("FAIL %s loopback: byte got %h expected %h",
               name, model_decode(rx), d);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    t_enable    = 1'b1;
    parallel_in = 8'hFF;
    err_pos     = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({t_busy, serial_out} !== 2'b01) begin
        errors++;
        $display("FAIL reset cycle %0d: busy/line got %b%b expected 01",
                 i, t_busy, serial_out);
      end
    end
    t_enable = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    checks++;
    if ({t_busy, serial_out} !== 2'b01) begin
      errors++;
      $display("FAIL reset release: busy/line got %b%b expected 01",
               t_busy, serial_out);
    end
  endtask

  task automatic test_known_vectors();
    logic [7:0]  din [3] = '{8'hA5, 8'h00, 8'hFF};
    logic [11:0] cw  [3] = '{12'hA27, 12'h000, 12'hF77};
    logic [11:0] rx;
    for (int i = 0; i < 3; i++) begin
      send_frame(din[i], 4'd0, -1, 1'b0, "known", rx);
      checks++;
      if (rx !== cw[i]) begin
        errors++;
        $display("FAIL known codeword %h: got %h expected %h", din[i], rx, cw[i]);
      end
    end
  endtask

  task automatic test_enable_ignored();
    logic [11:0] rx;
    send_frame(8'hA5, 4'd0, 20, 1'b0, "ignore_en", rx);
    // The poked request must not have started a second frame.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({t_busy, serial_out} !== 2'b01) begin
        errors++;
        $display("FAIL ignore_en idle %0d: busy/line got %b%b expected 01",
                 i, t_busy, serial_out);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] rx;
    parallel_in = 8'hC3;
    t_enable    = 1'b1;
    @(negedge clk);
    t_enable = 1'b0;
    // Frame cycle 37 is the middle of DATA bit 6.
    walk_frame(model_code(8'hC3), 38, -1, 1'b0, "abort", rx);
    reset    = 1'b0;
    t_enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({t_busy, serial_out} !== 2'b01) begin
        errors++;
        $display("FAIL abort reset %0d: busy/line got %b%b expected 01",
                 i, t_busy, serial_out);
      end
    end
    reset    = 1'b1;
    t_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({t_busy, serial_out} !== 2'b01) begin
        errors++;
        $display("FAIL abort resume %0d: busy/line got %b%b expected 01",
                 i, t_busy, serial_out);
      end
    end
    send_frame(8'h5A, 4'd0, -1, 1'b0, "after_abort", rx);
  endtask

  task automatic test_back_to_back();
    logic [11:0] rx;
    logic [7:0]  d;
    logic [3:0]  ep;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
`ifdef TX_ERR_INJECT_EN
      ep = 4'((i % 12) + 1);
`else
      ep = 4'd0;
`endif
      send_frame(d, ep, -1, 1'b1, "b2b", rx);
    end
  endtask

  initial begin
    reset       = 1'b0;
    t_enable    = 1'b0;
    parallel_in = '0;
    err_pos     = '0;
    @(negedge clk);
    test_reset();
    test_known_vectors();
    test_enable_ignored();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_hamming_uart_tx

// File: doc/hamming_uart_tx.md
HAMMING_UART_TX -- requirements
Module: hamming_uart_tx

Interface
REQ-001 Parameter CYCLES_PER_BIT, default 868, clk cycles per serial bit; legal range 2..1023.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge).
REQ-004 parallel_in  input  8  data byte to send; sampled only on accept.
REQ-005 t_enable  input  1  send request; accepted only in IDLE.
REQ-006 serial_out  output  1  UART line; idle high.
REQ-007 t_busy  output  1  high while a frame is in progress (state != IDLE).
REQ-008 err_pos  input  4  present only with TX_ERR_INJECT_EN (see Configuration).

Function
REQ-009 The FSM SHALL have states IDLE, START, DATA and STOP, with serial_out=1 in IDLE, 0 in START, codeword bit in DATA, and 1 in STOP.
REQ-010 In IDLE with t_enable==1, the block SHALL latch the Hamming(12,8) codeword of parallel_in and enter START on the same edge; serial_out SHALL go low and t_busy high one cycle after accept.
REQ-011 Codeword mapping SHALL be: c[11:8]=d[7:4], c[6:4]=d[3:1], c[2]=d[0].
REQ-012 Parity SHALL be: c[0]=c2^c4^c6^c8^c10; c[1]=c2^c5^c6^c9^c10; c[3]=c4^c5^c6^c11; c[7]=c8^c9^c10^c11.
REQ-013 DATA SHALL shift out 12 bits MSB first (c[11] first, c[0] last), each held exactly CYCLES_PER_BIT cycles.
REQ-014 START and STOP SHALL each last exactly CYCLES_PER_BIT cycles; the total frame SHALL be 14*CYCLES_PER_BIT cycles of t_busy high.
REQ-015 A 10-bit cycle counter SHALL wrap to 0 at CYCLES_PER_BIT-1; a 4-bit bit counter SHALL count 0..11 in DATA and clear on entering STOP.
REQ-016 While t_busy is high, t_enable SHALL be ignored and parallel_in changes SHALL NOT affect the frame in flight.
REQ-017 After STOP, the block SHALL return to IDLE; if t_enable is high in that first IDLE cycle, a new frame SHALL be accepted (minimum 1 idle cycle between frames).
REQ-018 serial_out SHALL be registered (glitch-free).

Reset
REQ-019 While reset==0, the block SHALL set state=IDLE, serial_out=1, t_busy=0, and clear both counters and the codeword register.
REQ-020 A reset asserted mid-frame SHALL abort the frame at the next edge, with serial_out=1 and no partial resume afterwards.
REQ-021 When reset==0 and t_enable==1 occur together, reset SHALL win and no frame SHALL start.

Configuration
REQ-022 Macro TX_ERR_INJECT_EN, when defined, SHALL add the err_pos port; on accept, if err_pos is 1..12, codeword bit c[err_pos-1] SHALL be inverted before transmit, and err_pos values 0 or 13..15 SHALL inject nothing.
REQ-023 Without TX_ERR_INJECT_EN, the err_pos port and all injection logic SHALL be absent, and the transmitted codeword SHALL be exactly REQ-011/012.

Structure
REQ-024 Package uart_hamming_pkg SHALL hold the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3), the CODE_W=12 and DATA_W=8 constants, the parity-position constants (0,1,3,7), and the default CYCLES_PER_BIT=868.
REQ-025 The combinational encoder SHALL be a sub-module hamming_enc_12_8 (d[7:0] -> c[11:0]); the package SHALL be shared with the receiver.

Verification (CYCLES_PER_BIT=5)
REQ-026 Send 0xA5 -> line shows 0, then bits 1010_0010_0111 (codeword 0xA27) MSB first, then 1, each 5 cycles; t_busy high for 70 cycles.
REQ-027 Send 0x00 -> codeword 0x000; send 0xFF -> codeword 0xF77.
REQ-028 Pulse t_enable with 0x3C at cycle 20 of a 0xA5 frame -> 0xA5 frame unchanged, 0x3C not sent.
REQ-029 Drive reset=0 during DATA bit 6 -> serial_out=1 and t_busy=0 the next cycle; a following send of 0x5A -> full correct frame.
REQ-030 Loopback into the existing receiver, 256 bytes back-to-back -> every parallel_out equals the sent byte; with TX_ERR_INJECT_EN and err_pos=1..12 cycling -> all bytes still correctly recovered.
